seg7_led_ctrl: RTL



---
 rtl/seg7_led_pkg.sv | 67 ++++++
 rtl/seg7_hex_decode.sv | 18 +
 rtl/seg7_led_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_led_pkg
//  Description : Shared constants, register-map decode and hex segment table
//                for the seven-segment / LED controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_led_pkg;

   // Word offsets inside the 32-word register window
   localparam logic [4:0] ADDR_CTRL       = 5'h00;
   localparam logic [4:0] ADDR_LED        = 5'h01;
   localparam logic [4:0] ADDR_BLINK      = 5'h02;
   localparam logic [4:0] ADDR_ID         = 5'h03;
   localparam logic [4:0] ADDR_DIGIT_BASE = 5'h08;

   // CTRL register field positions
   localparam int CTRL_MODE_BIT = 0;
   localparam int CTRL_EN_BIT   = 1;
   localparam int CTRL_DUTY_LSB = 8;

   // Upper byte of the ID register
   localparam logic [7:0] ID_MAGIC = 8'h5A;

   // Active-low pattern for a dark digit (DP and all segments off)
   localparam logic [7:0] BLANK = 8'hFF;

   // Hex glyphs, active-high, bit order g..a
   localparam logic [6:0] SEG_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
   };

   // Register targeted by a bus access
   typedef enum logic [2:0] {
      SEL_CTRL  = 3'd0,
      SEL_LED   = 3'd1,
      SEL_BLINK = 3'd2,
      SEL_ID    = 3'd3,
      SEL_DIGIT = 3'd4,
      SEL_NONE  = 3'd5
   } reg_sel_e;

   // Map a word address onto a register; digits beyond the instantiated
   // count fall into the unmapped bucket like any other hole.
   function automatic reg_sel_e decode_addr(input logic [4:0] addr, input int num_digits);
      reg_sel_e sel;
      sel = SEL_NONE;
      if (addr == ADDR_CTRL) begin
         sel = SEL_CTRL;
      end else if (addr == ADDR_LED) begin
         sel = SEL_LED;
      end else if (addr == ADDR_BLINK) begin
         sel = SEL_BLINK;
      end else if (addr == ADDR_ID) begin
         sel = SEL_ID;
      end else if ((addr >= ADDR_DIGIT_BASE) &&
                   ((int'(addr) - int'(ADDR_DIGIT_BASE)) < num_digits)) begin
         sel = SEL_DIGIT;
      end
      return sel;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decode
//  Description : 4-bit hex nibble to active-high g..a segment pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
   import seg7_led_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   // Pure table lookup; the caller registers the result
   assign seg = SEG_HEX[hex];

endmodule
`default_nettype wire

// File: rtl/seg7_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_led_ctrl
//  Description : Avalon-MM slave driving NUM_DIGITS active-low HEX digits and
//                an LED bank, with hex/raw digit modes, per-digit blink and
//                glitch-free global PWM brightness. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_led_ctrl
   import seg7_led_pkg::*;
#(
   parameter int NUM_DIGITS   = 6,
   parameter int LED_WIDTH    = 10,
   parameter int PWM_BITS     = 8,
   parameter int BLINK_CYCLES = 25000000
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4:0]              avs_address,
   input  logic                    avs_read,
   input  logic                    avs_write,
   input  logic [31:0]             avs_writedata,
   input  logic [3:0]              avs_byteenable,
   output logic [31:0]             avs_readdata,
   output logic [NUM_DIGITS*8-1:0] seg_export,
   output logic [LED_WIDTH-1:0]    led_export
);

   localparam int                 BLINK_W    = $clog2(BLINK_CYCLES);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   logic                  ctrl_mode;
   logic                  ctrl_en;
   logic [PWM_BITS-1:0]   ctrl_duty;
   logic [LED_WIDTH-1:0]  led_reg;
   logic [NUM_DIGITS-1:0] blink_mask;
   logic [7:0]            digit_reg [NUM_DIGITS];

   // PWM and blink timing state
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic [PWM_BITS-1:0]   duty_act;
   logic [BLINK_W-1:0]    blink_cnt;
   logic                  blink_phase;

   // Bus decode helpers
   reg_sel_e              sel;
   logic [4:0]            digit_idx;
   logic [31:0]           be_mask;
   logic [31:0]           rdata;

   // Next-state of the output registers
   logic                  pwm_on;
   logic                  lit_all;
   logic [NUM_DIGITS*8-1:0] seg_next;

   // Not every write-data lane maps to a register bit for every parameter set
   logic                  unused_bus_bits;
   assign unused_bus_bits = ^{avs_writedata, be_mask};

   assign sel       = decode_addr(avs_address, NUM_DIGITS);
   assign digit_idx = avs_address - ADDR_DIGIT_BASE;
   assign be_mask   = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                       {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};

   // Register writes, merged per byte lane so disabled lanes keep old bits
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_mode  <= 1'b0;
         ctrl_en    <= 1'b1;
         ctrl_duty  <= '1;
         led_reg    <= '0;
         blink_mask <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_reg[i] <= '0;
         end
      end else if (avs_write) begin
         case (sel)
            SEL_CTRL: begin
               if (avs_byteenable[0]) begin
                  ctrl_mode <= avs_writedata[CTRL_MODE_BIT];
                  ctrl_en   <= avs_writedata[CTRL_EN_BIT];
               end
               ctrl_duty <= (ctrl_duty & ~be_mask[CTRL_DUTY_LSB +: PWM_BITS]) |
                            (avs_writedata[CTRL_DUTY_LSB +: PWM_BITS] &
                             be_mask[CTRL_DUTY_LSB +: PWM_BITS]);
            end
            SEL_LED: begin
               led_reg <= (led_reg & ~be_mask[LED_WIDTH-1:0]) |
                          (avs_writedata[LED_WIDTH-1:0] & be_mask[LED_WIDTH-1:0]);
            end
            SEL_BLINK: begin
               blink_mask <= (blink_mask & ~be_mask[NUM_DIGITS-1:0]) |
                             (avs_writedata[NUM_DIGITS-1:0] & be_mask[NUM_DIGITS-1:0]);
            end
            SEL_DIGIT: begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if ((digit_idx == 5'(i)) && avs_byteenable[0]) begin
                     digit_reg[i] <= avs_writedata[7:0];
                  end
               end
            end
            default: begin
               // ID and unmapped addresses are read-only / ignored
            end
         endcase
      end
   end

   // Read mux over the current (pre-write) register contents
   always_comb begin
      rdata = '0;
      case (sel)
         SEL_CTRL: begin
            rdata[CTRL_MODE_BIT]               = ctrl_mode;
            rdata[CTRL_EN_BIT]                 = ctrl_en;
            rdata[CTRL_DUTY_LSB +: PWM_BITS]   = ctrl_duty;
         end
         SEL_LED:   rdata[LED_WIDTH-1:0]  = led_reg;
         SEL_BLINK: rdata[NUM_DIGITS-1:0] = blink_mask;
         SEL_ID:    rdata = {ID_MAGIC, 8'd0, 8'(LED_WIDTH), 8'(NUM_DIGITS)};
         SEL_DIGIT: begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (digit_idx == 5'(i)) begin
                  rdata[7:0] = digit_reg[i];
               end
            end
         end
         default: rdata = '0;
      endcase
   end

   // Read data captured one cycle after the strobe and held until the next read
   always_ff @(posedge clk) begin
      if (reset) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         avs_readdata <= rdata;
      end
   end

   // ------------------------------------------------------------------
   // Brightness: duty is only adopted at the period boundary so a period is
   // never cut short or stretched by a CTRL write.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt  <= '0;
         duty_act <= '1;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (pwm_cnt == '1) begin
            duty_act <= ctrl_duty;
         end
      end
   end

   // Blink half-period timer; phase toggles on every wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
      end
   end

   // All-ones duty means permanently on, otherwise on for the first duty counts
   assign pwm_on  = (pwm_cnt < duty_act) || (&duty_act);
   assign lit_all = ctrl_en && pwm_on;

   // Per-digit glyph selection and blanking
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [6:0] hex_seg;
         logic [6:0] seg_sel;
         logic       blanked;

         seg7_hex_decode u_hex_decode (
            .hex (digit_reg[gi][3:0]),
            .seg (hex_seg)
         );

         assign seg_sel = ctrl_mode ? digit_reg[gi][6:0] : hex_seg;
         assign blanked = blink_mask[gi] && blink_phase;
         assign seg_next[8*gi +: 8] = (lit_all && !blanked) ? ~{digit_reg[gi][7], seg_sel}
                                                            : BLANK;
      end
   endgenerate

   // Registered pin drivers
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_export <= '1;
         led_export <= '0;
      end else begin
         seg_export <= seg_next;
         led_export <= led_reg & {LED_WIDTH{lit_all}};
      end
   end

endmodule
`default_nettype wire
